// File: rtl/fp_align_seq_if.sv
// Handshake and result bundle for the FP add alignment stage.
// Ports: in_valid/in_ready/A/B in, out_valid/out_ready plus result fields out.
interface fp_align_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic        out_ready;
  logic        ANaN;
  logic        BNaN;
  logic        Ainf;
  logic        Binf;
  logic        Azero;
  logic        Bzero;
  logic        Asub;
  logic        Bsub;
  logic        signA;
  logic        signB;
  logic [31:0] A_q;
  logic [31:0] B_q;
  logic        alignedSign;
  logic [7:0]  exponentOut;
  logic [31:0] alignedResult;
  logic        carryOut;
  logic        sticky;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid,
    input  ANaN, BNaN, Ainf, Binf, Azero, Bzero, Asub, Bsub,
    input  signA, signB, A_q, B_q,
    input  alignedSign, exponentOut, alignedResult, carryOut, sticky
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid,
    output ANaN, BNaN, Ainf, Binf, Azero, Bzero, Asub, Bsub,
    output signA, signB, A_q, B_q,
    output alignedSign, exponentOut, alignedResult, carryOut, sticky
  );
endinterface

// File: rtl/fp_align_seq.sv
// Sequential FP add front end: classify, swap, align by stepped shifts, add.
// Ports: clk, reset (sync, active-high), bus (fp_align_seq_if.slave).
module fp_align_seq #(
  parameter int SHIFT_STEP = 4
) (
  input logic          clk,
  input logic          reset,
  fp_align_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, SHIFT, ADD, DONE
  } state_t;

  localparam logic [5:0] STEP = 6'(SHIFT_STEP);

  state_t st, st_nx;

  logic [31:0] big_m, small_m;
  logic [5:0]  rem;
  logic        sgn_big, sgn_small;

  // Operand decode, only meaningful while idle
  logic [7:0]  ea, eb, eea, eeb, ediff, emax;
  logic [22:0] fa, fb;
  logic [31:0] ma, mb;
  logic        a_nan, b_nan, a_inf, b_inf;
  logic        a_zero, b_zero, a_sub, b_sub;
  logic        a_big, special;
  logic [5:0]  d_cl;

  assign ea     = bus.A[30:23];
  assign eb     = bus.B[30:23];
  assign fa     = bus.A[22:0];
  assign fb     = bus.B[22:0];
  assign a_nan  = (&ea) && (|fa);
  assign b_nan  = (&eb) && (|fb);
  assign a_inf  = (&ea) && !(|fa);
  assign b_inf  = (&eb) && !(|fb);
  assign a_zero = !(|ea) && !(|fa);
  assign b_zero = !(|eb) && !(|fb);
  assign a_sub  = !(|ea) && (|fa);
  assign b_sub  = !(|eb) && (|fb);
  assign ma     = {|ea, fa, 8'b0};
  assign mb     = {|eb, fb, 8'b0};
  assign eea    = (ea == 8'd0) ? 8'd1 : ea;
  assign eeb    = (eb == 8'd0) ? 8'd1 : eb;
  assign a_big  = (eea > eeb) || ((eea == eeb) && (ma >= mb));
  assign ediff  = a_big ? (eea - eeb) : (eeb - eea);
  assign d_cl   = (ediff > 8'd34) ? 6'd34 : ediff[5:0];
  assign emax   = (ea > eb) ? ea : eb;
  assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

  // Stepped shift: the low 34 bits catch whatever falls off bit 0
  logic [5:0]  sh;
  logic [65:0] sh_w;
  logic [32:0] sum;
  logic [31:0] dif;

  assign sh   = (rem > STEP) ? STEP : rem;
  assign sh_w = {small_m, 34'b0} >> sh;
  assign sum  = {1'b0, big_m} + {1'b0, small_m};
  assign dif  = big_m - small_m - {31'b0, bus.sticky};

  always_ff @(posedge clk) begin
    if (reset) st <= IDLE;
    else       st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE: begin
        if (bus.in_valid) begin
          if (special)           st_nx = DONE;
          else if (d_cl != 6'd0) st_nx = SHIFT;
          else                   st_nx = ADD;
        end
      end
      SHIFT: if (rem <= STEP) st_nx = ADD;
      ADD:   st_nx = DONE;
      DONE:  if (bus.out_ready) st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (st == IDLE);
    bus.out_valid = (st == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      big_m             <= '0;
      small_m           <= '0;
      rem               <= '0;
      sgn_big           <= 1'b0;
      sgn_small         <= 1'b0;
      bus.ANaN          <= 1'b0;
      bus.BNaN          <= 1'b0;
      bus.Ainf          <= 1'b0;
      bus.Binf          <= 1'b0;
      bus.Azero         <= 1'b0;
      bus.Bzero         <= 1'b0;
      bus.Asub          <= 1'b0;
      bus.Bsub          <= 1'b0;
      bus.signA         <= 1'b0;
      bus.signB         <= 1'b0;
      bus.A_q           <= '0;
      bus.B_q           <= '0;
      bus.alignedSign   <= 1'b0;
      bus.exponentOut   <= '0;
      bus.alignedResult <= '0;
      bus.carryOut      <= 1'b0;
      bus.sticky        <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (bus.in_valid) begin
            bus.A_q           <= bus.A;
            bus.B_q           <= bus.B;
            bus.ANaN          <= a_nan;
            bus.BNaN          <= b_nan;
            bus.Ainf          <= a_inf;
            bus.Binf          <= b_inf;
            bus.Azero         <= a_zero;
            bus.Bzero         <= b_zero;
            bus.Asub          <= a_sub;
            bus.Bsub          <= b_sub;
            bus.signA         <= bus.A[31];
            bus.signB         <= bus.B[31];
            bus.exponentOut   <= emax;
            bus.alignedSign   <= 1'b0;
            bus.alignedResult <= '0;
            bus.carryOut      <= 1'b0;
            bus.sticky        <= 1'b0;
            big_m             <= a_big ? ma : mb;
            small_m           <= a_big ? mb : ma;
            sgn_big           <= a_big ? bus.A[31] : bus.B[31];
            sgn_small         <= a_big ? bus.B[31] : bus.A[31];
            rem               <= d_cl;
          end
        end
        SHIFT: begin
          small_m    <= sh_w[65:34];
          bus.sticky <= bus.sticky | (|sh_w[33:0]);
          rem        <= rem - sh;
        end
        ADD: begin
          if (sgn_big == sgn_small) begin
            {bus.carryOut, bus.alignedResult} <= sum;
            bus.alignedSign <= sgn_big;
          end else begin
            bus.alignedResult <= dif;
            bus.carryOut      <= 1'b0;
            bus.alignedSign   <= (dif == 32'd0) ? 1'b0 : sgn_big;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_align_seq.sv
// Directed bench for fp_align_seq with hand-computed expected results.
// Drives the interface master side; checks latency and result fields.
module tb_fp_align_seq;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;
  int   lat;
  logic [31:0] snap;

  always #5 clk = ~clk;

  fp_align_seq_if bus ();

  fp_align_seq #(.SHIFT_STEP(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Accept a pair, then count edges until out_valid (accept edge = 1)
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    bus.A        = a;
    bus.B        = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_done();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("rel_ovalid", 32'(bus.out_valid), 32'd0);
    chk("rel_iready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_iready", 32'(bus.in_ready), 32'd1);
    chk("rst_ovalid", 32'(bus.out_valid), 32'd0);
    chk("rst_res", bus.alignedResult, 32'd0);
    chk("rst_aq", bus.A_q, 32'd0);
    chk("rst_sticky", 32'(bus.sticky), 32'd0);
    reset = 1'b0;

    // 1.0 + 1.0
    send(32'h3F800000, 32'h3F800000);
    chk("t1_lat", 32'(lat), 32'd2);
    chk("t1_carry", 32'(bus.carryOut), 32'd1);
    chk("t1_res", bus.alignedResult, 32'h00000000);
    chk("t1_exp", 32'(bus.exponentOut), 32'h7F);
    chk("t1_sticky", 32'(bus.sticky), 32'd0);
    chk("t1_sign", 32'(bus.alignedSign), 32'd0);
    release_done();

    // 1.0 + 0.0625, d=4
    send(32'h3F800000, 32'h3D800000);
    chk("t2_lat", 32'(lat), 32'd3);
    chk("t2_res", bus.alignedResult, 32'h88000000);
    chk("t2_carry", 32'(bus.carryOut), 32'd0);
    chk("t2_sticky", 32'(bus.sticky), 32'd0);
    chk("t2_exp", 32'(bus.exponentOut), 32'h7F);
    release_done();

    // 1.0 - 1.0
    send(32'h3F800000, 32'hBF800000);
    chk("t3_lat", 32'(lat), 32'd2);
    chk("t3_res", bus.alignedResult, 32'h00000000);
    chk("t3_sign", 32'(bus.alignedSign), 32'd0);
    chk("t3_carry", 32'(bus.carryOut), 32'd0);
    release_done();

    // d=40 clamped to 34: 9 shift cycles
    send(32'h3F800000, 32'h2B800000);
    chk("t4_lat", 32'(lat), 32'd11);
    chk("t4_sticky", 32'(bus.sticky), 32'd1);
    chk("t4_res", bus.alignedResult, 32'h80000000);
    chk("t4_exp", 32'(bus.exponentOut), 32'h7F);
    release_done();

    // NaN operand; sticky must be cleared by acceptance
    send(32'h7FC00000, 32'h3F800000);
    chk("t5_lat", 32'(lat), 32'd1);
    chk("t5_anan", 32'(bus.ANaN), 32'd1);
    chk("t5_bnan", 32'(bus.BNaN), 32'd0);
    chk("t5_res", bus.alignedResult, 32'd0);
    chk("t5_aq", bus.A_q, 32'h7FC00000);
    chk("t5_exp", 32'(bus.exponentOut), 32'hFF);
    chk("t5_sticky", 32'(bus.sticky), 32'd0);
    release_done();

    // 2.0 + (-1.0): d=1
    send(32'h40000000, 32'hBF800000);
    chk("t6_lat", 32'(lat), 32'd3);
    chk("t6_res", bus.alignedResult, 32'h40000000);
    chk("t6_sign", 32'(bus.alignedSign), 32'd0);
    chk("t6_exp", 32'(bus.exponentOut), 32'h80);
    release_done();

    // 1.0 + (-2.0): B is big, result negative
    send(32'h3F800000, 32'hC0000000);
    chk("t7_res", bus.alignedResult, 32'h40000000);
    chk("t7_sign", 32'(bus.alignedSign), 32'd1);
    chk("t7_signb", 32'(bus.signB), 32'd1);
    chk("t7_exp", 32'(bus.exponentOut), 32'h80);
    release_done();

    // Subtraction with sticky: d=24, 6 shift cycles
    send(32'h3F800000, 32'hB3800001);
    chk("t8_lat", 32'(lat), 32'd8);
    chk("t8_sticky", 32'(bus.sticky), 32'd1);
    chk("t8_res", bus.alignedResult, 32'h7FFFFF7F);
    chk("t8_carry", 32'(bus.carryOut), 32'd0);
    release_done();

    // Two subnormals, B larger
    send(32'h00000001, 32'h00000002);
    chk("t9_lat", 32'(lat), 32'd2);
    chk("t9_res", bus.alignedResult, 32'h00000300);
    chk("t9_exp", 32'(bus.exponentOut), 32'h00);
    chk("t9_asub", 32'(bus.Asub), 32'd1);
    chk("t9_bsub", 32'(bus.Bsub), 32'd1);

    // Hold in DONE with out_ready low
    snap = bus.alignedResult;
    bus.A        = 32'h3F800000;
    bus.B        = 32'h3F800000;
    bus.in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("hold_ovalid", 32'(bus.out_valid), 32'd1);
    chk("hold_iready", 32'(bus.in_ready), 32'd0);
    chk("hold_res", bus.alignedResult, snap);
    chk("hold_aq", bus.A_q, 32'h00000001);
    release_done();

    // Reset during SHIFT discards the operation
    bus.A        = 32'h3F800000;
    bus.B        = 32'h2B800000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_iready", 32'(bus.in_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst2_ovalid", 32'(bus.out_valid), 32'd0);
    chk("rst2_iready", 32'(bus.in_ready), 32'd1);
    chk("rst2_sticky", 32'(bus.sticky), 32'd0);
    chk("rst2_bq", bus.B_q, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
